alu_cmd_issue: RTL and testbench

Command-queue and issue stage directly upstream of the team's 4-bit combinational `alu`. It accepts `{op, a, b}` commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drives each command into the ALU from registered outputs, captures the ALU result one cycle later, and presents it downstream with a valid/ready handshake, tagged with its opcode. Results are returned in strict command order.

---
 rtl/alu_cmd_issue.sv | 146 ++++++++++++++
 tb/tb_alu_cmd_issue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue.sv
// Command FIFO + issue stage feeding the combinational 4-bit alu; results return in order, tagged with opcode.
// Latency: push at edge k into an idle, empty block -> popped at k+1, out_valid high after k+2; one result per 2 cycles max.
// Backpressure: in_ready drops when the FIFO is full (no bypass); a result stalled by out_ready holds out_y/out_op and blocks issue.
module alu_cmd_issue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_a,
  input  logic [3:0]             in_b,
  input  logic [2:0]             in_op,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_s,
  input  logic [3:0]             alu_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_y,
  output logic [2:0]             out_op,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESULT
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          in_cmd;
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          push;
  logic          pop;
  logic          has_cmd;
  state_t        state_q;
  state_t        state_d;

  assign in_cmd   = '{op: in_op, a: in_a, b: in_b};
  assign head     = mem[rd_ptr];
  assign in_ready = (cnt_q != CW'(DEPTH));
  assign count    = cnt_q;
  assign has_cmd  = (cnt_q != '0);
  assign push     = in_valid && in_ready;

  // Storage carries no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // pop is only ever raised when has_cmd, so the FIFO never underflows.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (has_cmd) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESULT;
      end
      RESULT: begin
        if (out_ready) begin
          if (has_cmd) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      out_y     <= '0;
      out_op    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pop) begin
        alu_a <= head.a;
        alu_b <= head.b;
        alu_s <= head.op;
      end
      if (state_q == EXEC) begin
        out_y  <= alu_y;
        out_op <= alu_s;
      end
      out_valid <= (state_d == RESULT);
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: models the alu, scoreboards results in command order, plus directed latency/full/reset cases.
module tb_alu_cmd_issue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic [3:0] alu_y;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic [2:0] out_op;
  logic [$clog2(DEPTH):0] count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_op(out_op),
    .count(count)
  );

  function automatic logic [3:0] alu_fn(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    int av;
    int bv;
    av = int'(a);
    bv = int'(b);
    case (s)
      3'd0:    return 4'((av + bv) % 16);
      3'd1:    return 4'((av - bv + 16) % 16);
      3'd2:    return a ^ b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return ~(a ^ b);
      3'd6:    return (bv >= 4) ? 4'd0 : 4'((av * (1 << bv)) % 16);
      default: return (bv >= 4) ? 4'd0 : 4'(av / (1 << bv));
    endcase
  endfunction

  always_comb alu_y = alu_fn(alu_s, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  // Monitor: records accepted commands, compares delivered results, checks hold-while-stalled.
  initial begin
    logic       prev_stall;
    logic [3:0] prev_y;
    logic [2:0] prev_op;
    logic [6:0] e;
    prev_stall = 1'b0;
    prev_y     = '0;
    prev_op    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (in_valid && in_ready) exp_q.push_back({alu_fn(in_op, in_a, in_b), in_op});
        if (prev_stall && out_valid) begin
          chk("hold_y", 32'(out_y), 32'(prev_y));
          chk("hold_op", 32'(out_op), 32'(prev_op));
        end
        prev_stall = out_valid && !out_ready;
        prev_y     = out_y;
        prev_op    = out_op;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_result", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_y", 32'(out_y), 32'(e[6:3]));
            chk("sb_op", 32'(out_op), 32'(e[2:0]));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input bit rnd);
    bit acc;
    int n;
    n        = 0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_result(input logic [3:0] y, input logic [2:0] op, input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_y"}, 32'(out_y), 32'(y));
    chk({nm, "_op"}, 32'(out_op), 32'(op));
    tick();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      tick();
      n++;
    end
    chk({nm, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_count"}, 32'(count), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_count"}, 32'(count), 32'd0);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({nm, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({nm, "_alu_s"}, 32'(alu_s), 32'd0);
    chk({nm, "_out_y"}, 32'(out_y), 32'd0);
    chk({nm, "_out_op"}, 32'(out_op), 32'd0);
  endtask

  initial begin
    logic [3:0] fa;
    logic [3:0] fb;
    logic [2:0] fop;
    bit acc;
    int n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    #3;
    check_reset_vals("rst0");
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick();

    // Single command: exact two-cycle latency.
    out_ready = 1'b1;
    push_cmd(4'd3, 4'd5, 3'b000, 1'b0);
    chk("single_count_after_push", 32'(count), 32'd1);
    chk("single_valid_k", 32'(out_valid), 32'd0);
    tick();
    chk("single_valid_k1", 32'(out_valid), 32'd0);
    chk("single_count_k1", 32'(count), 32'd0);
    tick();
    chk("single_valid_k2", 32'(out_valid), 32'd1);
    chk("single_y", 32'(out_y), 32'd8);
    chk("single_op", 32'(out_op), 32'd0);
    tick();
    chk("single_valid_after", 32'(out_valid), 32'd0);

    // Wrap and shift.
    push_cmd(4'd2, 4'd5, 3'b001, 1'b0);
    push_cmd(4'b0011, 4'd2, 3'b110, 1'b0);
    wait_result(4'hD, 3'b001, "sub_wrap");
    wait_result(4'b1100, 3'b110, "shl");
    drain("ws");

    // Backpressure and full.
    out_ready = 1'b0;
    fa  = 4'($urandom_range(0, 15));
    fb  = 4'($urandom_range(0, 15));
    fop = 3'($urandom_range(0, 7));
    push_cmd(fa, fb, fop, 1'b0);
    for (int i = 0; i < 4; i++)
      push_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    in_a     = 4'($urandom_range(0, 15));
    in_b     = 4'($urandom_range(0, 15));
    in_op    = 3'($urandom_range(0, 7));
    in_valid = 1'b1;
    repeat (3) tick();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_count", 32'(count), 32'd4);
    chk("stall_y", 32'(out_y), 32'(alu_fn(fop, fa, fb)));
    chk("stall_op", 32'(out_op), 32'(fop));
    out_ready = 1'b1;
    n = 0;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    chk("sixth_accepted", 32'(acc), 32'd1);
    drain("bp");

    // Simultaneous push/pop in RESULT with two queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b0);
    chk("pp_pre_count", 32'(count), 32'd2);
    chk("pp_pre_valid", 32'(out_valid), 32'd1);
    in_a      = 4'($urandom_range(0, 15));
    in_b      = 4'($urandom_range(0, 15));
    in_op     = 3'($urandom_range(0, 7));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pp_count", 32'(count), 32'd2);
    drain("pp");

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b0);
    chk("mr_pre_count", 32'(count), 32'd3);
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    exp_q.delete();
    rst = 1'b0;
    tick();
    repeat (3) tick();
    chk("no_stale_valid", 32'(out_valid), 32'd0);
    chk("no_stale_count", 32'(count), 32'd0);
    out_ready = 1'b1;
    push_cmd(4'd7, 4'd1, 3'b111, 1'b0);
    wait_result(4'd3, 3'b111, "post_rst");
    drain("mr");

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      push_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b1);
    end
    drain("rand");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
